cpu_seq_ctrl: RTL and testbench
===============================

// Module: cpu_seq_ctrl
// PURPOSE
//   Multi-cycle control sequencer for the 16-bit SimpleCPU datapath. Owns PC and IR.
//   Fetches over a req/ack handshake, decodes, and drives register-file, ALU and flag
//   controls. Retires ALU, branch, NOP and HALT instructions.
//   Sits between the instruction memory and the register-file/ALU datapath.
// PARAMETERS
//   PC_W     8    PC / instruction-address width; PC wraps modulo 2**PC_W
//   RCNT_W   16   width of retired-instruction counter (wraps)
// PORTS
//   clk          in   1        system clock, rising edge
//   reset        in   1        synchronous, active-high
//   mem_req      out  1        fetch request, held until mem_ack
//   mem_addr     out  PC_W     fetch address (= pc)
//   mem_ack      in   1        instr valid this cycle; sampled only while mem_req=1
//   mem_rdata    in   16       instruction word
//   zero_in      in   1        datapath zero flag (registered in datapath)
//   rs1_addr     out  3        IR[11:9]
//   rs2_addr     out  3        IR[8:6]
//   rd_addr      out  3        IR[5:3]
//   alu_op       out  2        00 ADD, 01 SUB, 10 AND, 11 OR
//   rf_we        out  1        register-file write strobe
//   flag_we      out  1        zero-flag update strobe (same cycle as rf_we)
//   pc           out  PC_W     current PC
//   halted       out  1        sticky after HALT
//   illegal      out  1        sticky after undefined opcode
//   retire_cnt   out  RCNT_W   instructions retired since reset
// BEHAVIOUR
//   Reset: state=FETCH, pc=0, IR=0, retire_cnt=0, halted=0, illegal=0.
//     All strobes are 0 and mem_req=0 during the reset cycle.
//   Encoding: op=IR[15:12]. 0000 NOP; 1000 ADD; 1001 SUB; 1010 AND; 1011 OR;
//     1100 BEQZ (offset = sext IR[5:0]); 1111 HALT. Any other opcode is illegal.
//   States: FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT is terminal until reset.
//   FETCH: mem_req=1, mem_addr=pc. mem_ack is sampled combinationally.
//     On ack: IR<=mem_rdata, pc<=pc+1 -> DECODE. With no ack, stay and hold mem_req.
//   DECODE: 1 cycle. rs*/rd addrs valid from IR.
//   EXEC: alu_op driven.
//     ALU ops -> WB.
//     BEQZ: if zero_in=1, pc<=pc+sext(IR[5:0]) (pc already incremented), mod 2**PC_W.
//       Retire, -> FETCH.
//     NOP: retire, -> FETCH.
//     HALT: retire, halted<=1 -> HALT.
//     Illegal: illegal<=1, retire as NOP, -> FETCH.
//   WB: rf_we=1, flag_we=1 for exactly one cycle. Retire, -> FETCH.
//   Latency with ack on the first FETCH cycle: ALU = 4 cycles, BEQZ/NOP/HALT = 3 cycles.
//     Each cycle of ack delay adds 1.
//   alu_op holds its decoded value in DECODE, EXEC and WB; it is 00 elsewhere.
//   rf_we and flag_we are never asserted outside WB.
//   HALT state: mem_req=0, pc frozen, all strobes 0, mem_ack ignored.
//   retire_cnt increments once per retired instruction and wraps to 0 at all-ones.
//   Reset in any state, including mid-handshake: request dropped the same cycle.
//     FETCH with pc=0 on the next cycle. Sticky flags are cleared.
//   mem_ack while mem_req=0 is ignored.
// CONFIGURATION
//   CPU_SINGLE_STEP_EN defined:
//     Adds input step (1 bit).
//     FETCH asserts mem_req only after a step pulse has been latched.
//     The latch clears when the fetch is acked. One instruction runs per pulse.
//     A step pulse arriving while executing is latched for the next fetch.
//   CPU_SINGLE_STEP_EN undefined: no step port; fetches run back-to-back.
// TESTING
//   1. ADD word 16'b1000_000_001_010_000, ack on first cycle.
//      -> rf_we pulses in cycle 4; rd_addr=2; alu_op=00; pc=1; retire_cnt=1.
//   2. Ack delayed 3 cycles.
//      -> mem_req held 4 cycles, mem_addr stable; rf_we at cycle 7.
//   3. BEQZ offset 6'h3E (-2) at pc=5, zero_in=1 -> next mem_addr=4.
//      Same with zero_in=0 -> next mem_addr=6.
//   4. HALT at pc=2 -> halted=1, mem_req stays 0 for 20 cycles, retire_cnt=3.
//      Then reset -> pc=0, halted=0.
//   5. Opcode 0101 -> illegal=1, no rf_we, next fetch at pc+1.
//      Reset asserted while mem_req=1 -> mem_req=0 that cycle.
//   6. CPU_SINGLE_STEP_EN: no step for 10 cycles -> mem_req=0.
//      Two step pulses -> exactly 2 retirements.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer owning PC and IR for the SimpleCPU datapath.
// Optional macro CPU_SINGLE_STEP_EN adds a step input that gates each fetch on a latched pulse.
module cpu_seq_ctrl #(
  parameter int PC_W   = 8,
  parameter int RCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              zero_in,
  output logic [2:0]        rs1_addr,
  output logic [2:0]        rs2_addr,
  output logic [2:0]        rd_addr,
  output logic [1:0]        alu_op,
  output logic              rf_we,
  output logic              flag_we,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal,
  output logic [RCNT_W-1:0] retire_cnt
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, off;
  logic [15:0] ir_q, ir_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic halted_q, halted_d, illegal_q, illegal_d;
  logic go, fire, retire, is_alu, is_beqz, is_halt, legal, in_op;
  logic [3:0] op;
  assign op      = ir_q[15:12];
  assign is_alu  = op[3:2] == 2'b10;
  assign is_beqz = op == 4'hC;
  assign is_halt = op == 4'hF;
  assign legal   = is_alu | is_beqz | is_halt | (op == 4'h0);
  assign off     = PC_W'($signed(ir_q[5:0]));
  assign fire    = state_q == S_FETCH && go && mem_ack && !reset;
`ifdef CPU_SINGLE_STEP_EN
  logic step_q, step_d;
  assign go     = step_q;
  assign step_d = step | (step_q & ~fire);
  always_ff @(posedge clk) step_q <= reset ? 1'b0 : step_d;
`else
  assign go = 1'b1;
`endif
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: if (fire) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        retire    = !is_alu;
        state_d   = is_alu ? S_WB : is_halt ? S_HALT : S_FETCH;
        halted_d  = halted_q | is_halt;
        illegal_d = illegal_q | !legal;
        if (is_beqz && zero_in) pc_d = pc_q + off;
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    rcnt_d = rcnt_q + RCNT_W'(retire);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      rcnt_q    <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      rcnt_q    <= rcnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end
  // Reset gates the combinational strobes so a mid-handshake reset drops the request at once.
  assign in_op      = state_q == S_DECODE || state_q == S_EXEC || state_q == S_WB;
  assign mem_req    = state_q == S_FETCH && go && !reset;
  assign rf_we      = state_q == S_WB && !reset;
  assign flag_we    = rf_we;
  assign alu_op     = (in_op && is_alu && !reset) ? op[1:0] : 2'b00;
  assign mem_addr   = pc_q;
  assign pc         = pc_q;
  assign rs1_addr   = ir_q[11:9];
  assign rs2_addr   = ir_q[8:6];
  assign rd_addr    = ir_q[5:3];
  assign halted     = halted_q;
  assign illegal    = illegal_q;
  assign retire_cnt = rcnt_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed bench for cpu_seq_ctrl; write-back events are checked against a queue of expectations.
module tb_cpu_seq_ctrl;
  logic clk = 0, reset = 1, mem_ack = 0, zero_in = 0;
  logic [15:0] mem_rdata = '0;
`ifdef CPU_SINGLE_STEP_EN
  logic step = 0;
`endif
  logic mem_req, rf_we, flag_we, halted, illegal;
  logic [7:0] mem_addr, pc;
  logic [2:0] rs1_addr, rs2_addr, rd_addr;
  logic [1:0] alu_op;
  logic [15:0] retire_cnt;
  cpu_seq_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef CPU_SINGLE_STEP_EN
    .step(step),
`endif
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .zero_in(zero_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .rf_we(rf_we), .flag_we(flag_we), .pc(pc), .halted(halted),
    .illegal(illegal), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0, t0 = 0;
  typedef struct {logic [2:0] rd; logic [1:0] op; int due;} exp_t;
  exp_t sb[$];
  exp_t e_m;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (rf_we) begin
      if (sb.size() == 0) chk("rf_we_unexpected", 32'd1, 32'd0);
      else begin
        e_m = sb.pop_front();
        chk("wb_rd", 32'(rd_addr), 32'(e_m.rd));
        chk("wb_op", 32'(alu_op), 32'(e_m.op));
        chk("wb_cycle", cyc, e_m.due);
        chk("wb_flag_we", 32'(flag_we), 32'd1);
      end
    end else if (flag_we) chk("flag_we_alone", 32'd1, 32'd0);
  end
  task automatic wait_req(input logic [7:0] a);
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("req_timeout", 32'(n < 40), 32'd1);
    t0 = cyc;
    chk("fetch_addr", 32'(mem_addr), 32'(a));
    chk("alu_op_idle", 32'(alu_op), 32'd0);
  endtask
  task automatic give(input logic [15:0] w, input int dly, input logic [7:0] a);
    for (int i = 0; i < dly; i++) begin
      chk("req_hold", 32'(mem_req), 32'd1);
      chk("addr_hold", 32'(mem_addr), 32'(a));
      @(negedge clk);
    end
    chk("req_at_ack", 32'(mem_req), 32'd1);
    mem_ack = 1;
    mem_rdata = w;
    if (w[15:14] == 2'b10) sb.push_back('{w[5:3], w[13:12], t0 + dly + 3});
    @(negedge clk);
    mem_ack = 0;
  endtask
  task automatic instr(input logic [15:0] w, input int dly, input logic [7:0] a);
    wait_req(a);
    give(w, dly, a);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_retire", 32'(retire_cnt), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    reset = 0;
    @(negedge clk);
    instr(16'b1000_000_001_010_000, 0, 8'd0);
    wait_req(8'd1);
    chk("add_pc", 32'(pc), 32'd1);
    chk("add_retire", 32'(retire_cnt), 32'd1);
    give(16'b1001_011_100_101_000, 3, 8'd1);
    wait_req(8'd2);
    chk("sub_retire", 32'(retire_cnt), 32'd2);
    give(16'h0000, 0, 8'd2);
    instr(16'h0000, 0, 8'd3);
    instr(16'h0000, 0, 8'd4);
    zero_in = 1;
    instr(16'hC03E, 0, 8'd5);
    wait_req(8'd4);
    zero_in = 0;
    chk("beqz_taken_retire", 32'(retire_cnt), 32'd6);
    give(16'h0000, 0, 8'd4);
    instr(16'hC03E, 0, 8'd5);
    wait_req(8'd6);
    chk("beqz_nt_retire", 32'(retire_cnt), 32'd8);
    chk("illegal_before", 32'(illegal), 32'd0);
    give(16'h5000, 0, 8'd6);
    wait_req(8'd7);
    chk("illegal_set", 32'(illegal), 32'd1);
    chk("illegal_retire", 32'(retire_cnt), 32'd9);
    reset = 1;
    #1 chk("rst_drops_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("rst2_pc", 32'(pc), 32'd0);
    chk("rst2_illegal", 32'(illegal), 32'd0);
    chk("rst2_retire", 32'(retire_cnt), 32'd0);
    reset = 0;
    @(negedge clk);
    instr(16'h0000, 0, 8'd0);
    instr(16'h0000, 0, 8'd1);
    instr(16'hF000, 0, 8'd2);
    repeat (2) @(negedge clk);
    chk("halt_set", 32'(halted), 32'd1);
    mem_ack = 1;
    for (int i = 0; i < 20; i++) begin
      chk("halt_no_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    mem_ack = 0;
    chk("halt_pc", 32'(pc), 32'd3);
    chk("halt_retire", 32'(retire_cnt), 32'd3);
    reset = 1;
    @(negedge clk);
    chk("rst3_pc", 32'(pc), 32'd0);
    chk("rst3_halted", 32'(halted), 32'd0);
    reset = 0;
    @(negedge clk);
`ifdef CPU_SINGLE_STEP_EN
    for (int i = 0; i < 10; i++) begin
      chk("step_idle_req", 32'(mem_req), 32'd0);
      @(negedge clk);
    end
    step = 1;
    @(negedge clk);
    step = 0;
    instr(16'h0000, 0, 8'd0);
    step = 1;
    @(negedge clk);
    step = 0;
    instr(16'h0000, 0, 8'd1);
    repeat (12) @(negedge clk);
    chk("step_req_off", 32'(mem_req), 32'd0);
    chk("step_retire", 32'(retire_cnt), 32'd2);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
